rr_mux_arbiter: RTL and testbench

//  Round-robin arbiter and output register that sits directly upstream of the 4:1 mux.

---
 rtl/rr_mux_arbiter_if.sv | 34 +++
 rtl/rr_mux_arbiter.sv | 91 +++++++++
 tb/tb_rr_mux_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/rr_mux_arbiter_if.sv
// Purpose: bundles the request/data inputs, the mux select/grant outputs and
//          the valid/ready output port of rr_mux_arbiter.
// Ports (by modport):
//   slave  (arbiter side): in  req, in1..in4, out_ready
//                          out ack, c1, c2, gnt, out_valid, out, xfer_cnt
//   master (source/consumer side): the mirror of slave
interface rr_mux_arbiter_if #(
  parameter int WIDTH     = 2,
  parameter int CNT_WIDTH = 16
);
  logic [3:0]           req;
  logic [WIDTH-1:0]     in1;
  logic [WIDTH-1:0]     in2;
  logic [WIDTH-1:0]     in3;
  logic [WIDTH-1:0]     in4;
  logic [3:0]           ack;
  logic                 c1;
  logic                 c2;
  logic [3:0]           gnt;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out;
  logic [CNT_WIDTH-1:0] xfer_cnt;

  modport slave (
    input  req, in1, in2, in3, in4, out_ready,
    output ack, c1, c2, gnt, out_valid, out, xfer_cnt
  );

  modport master (
    output req, in1, in2, in3, in4, out_ready,
    input  ack, c1, c2, gnt, out_valid, out, xfer_cnt
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Purpose: round-robin arbiter over four WIDTH-bit sources feeding a 4:1 mux.
//          Registers the chosen word and the mux select {c1,c2}, presents the
//          word on a valid/ready port and counts accepted transfers.
// Ports:
//   clk  in  single clock, rising edge
//   rst  in  synchronous, active-high reset
//   bus  rr_mux_arbiter_if.slave: req/in1..in4/out_ready in,
//        ack (combinational), c1/c2/gnt/out_valid/out/xfer_cnt out (registered)
module rr_mux_arbiter #(
  parameter int WIDTH     = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  rr_mux_arbiter_if.slave bus
);

  logic [1:0]           ptr;
  logic [1:0]           idx;
  logic [1:0]           cand;
  logic                 found;
  logic                 load;
  logic                 xfer;
  logic [WIDTH-1:0]     sel_data;

  logic [1:0]           sel_q;
  logic [3:0]           gnt_q;
  logic                 valid_q;
  logic [WIDTH-1:0]     out_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  // The output register can take a new word when it is empty or being drained.
  assign load = (!valid_q || bus.out_ready) && (|bus.req) && !rst;
  assign xfer = valid_q && bus.out_ready;

  // First set request at or after ptr, ascending modulo 4.
  always_comb begin
    idx   = ptr;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && bus.req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = bus.in1;
    case (idx)
      2'd0:    sel_data = bus.in1;
      2'd1:    sel_data = bus.in2;
      2'd2:    sel_data = bus.in3;
      default: sel_data = bus.in4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (xfer) cnt_q <= cnt_q + 1'b1;
      if (load) begin
        out_q   <= sel_data;
        sel_q   <= idx;
        gnt_q   <= 4'b0001 << idx;
        valid_q <= 1'b1;
        ptr     <= idx + 2'd1;
      end else if (bus.out_ready) begin
        // Drained with nothing pending: select and data keep their last values.
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.ack       = load ? (4'b0001 << idx) : 4'b0000;
  assign bus.c1        = sel_q[1];
  assign bus.c2        = sel_q[0];
  assign bus.gnt       = gnt_q;
  assign bus.out_valid = valid_q;
  assign bus.out       = out_q;
  assign bus.xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_total = 0;

  rr_mux_arbiter_if #(.WIDTH(2), .CNT_WIDTH(16)) bus ();

  rr_mux_arbiter #(.WIDTH(2), .CNT_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sel();
    return {30'd0, bus.c1, bus.c2};
  endfunction

  initial begin
    rst           = 1'b1;
    bus.req       = 4'b1111;
    bus.out_ready = 1'b1;
    bus.in1 = 2'b11; bus.in2 = 2'b00; bus.in3 = 2'b01; bus.in4 = 2'b10;

    // 1 reset
    tick(); tick();
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_sel",   sel(), 0);
    chk("rst_gnt",   32'(bus.gnt), 0);
    chk("rst_cnt",   32'(bus.xfer_cnt), 0);
    chk("rst_ack",   32'(bus.ack), 0);

    // 2 single source
    rst = 1'b0; bus.req = 4'b0001;
    #1 chk("single_ack", 32'(bus.ack), 32'b0001);
    tick();
    chk("single_out",   32'(bus.out), 32'b11);
    chk("single_sel",   sel(), 0);
    chk("single_gnt",   32'(bus.gnt), 32'b0001);
    chk("single_valid", 32'(bus.out_valid), 1);

    // 3 round robin from a fresh pointer
    rst = 1'b1; bus.req = 4'b0000;
    tick();
    chk("rr_rst_cnt", 32'(bus.xfer_cnt), 0);
    rst = 1'b0; bus.req = 4'b1111;
    tick(); chk("rr_out0", 32'(bus.out), 32'b11); chk("rr_sel0", sel(), 0); chk("rr_cnt0", 32'(bus.xfer_cnt), 0);
    tick(); chk("rr_out1", 32'(bus.out), 32'b00); chk("rr_sel1", sel(), 1); chk("rr_cnt1", 32'(bus.xfer_cnt), 1);
    tick(); chk("rr_out2", 32'(bus.out), 32'b01); chk("rr_sel2", sel(), 2); chk("rr_cnt2", 32'(bus.xfer_cnt), 2);
    tick(); chk("rr_out3", 32'(bus.out), 32'b10); chk("rr_sel3", sel(), 3); chk("rr_cnt3", 32'(bus.xfer_cnt), 3);
    tick(); chk("rr_out4", 32'(bus.out), 32'b11); chk("rr_sel4", sel(), 0); chk("rr_cnt4", 32'(bus.xfer_cnt), 4);
    bus.req = 4'b0000;
    tick();
    chk("idle_valid", 32'(bus.out_valid), 0);
    chk("idle_cnt",   32'(bus.xfer_cnt), 5);
    chk("idle_out",   32'(bus.out), 32'b11);
    chk("idle_gnt",   32'(bus.gnt), 32'b0001);

    // 4 stall (ptr=1 here)
    bus.in2 = 2'b11; bus.in3 = 2'b01;
    bus.req = 4'b0110; bus.out_ready = 1'b0;
    tick();
    chk("stall_load_out", 32'(bus.out), 32'b11);
    chk("stall_load_sel", sel(), 1);
    chk("stall_load_gnt", 32'(bus.gnt), 32'b0010);
    for (int i = 0; i < 3; i++) begin
      chk("stall_ack", 32'(bus.ack), 0);
      tick();
      chk("stall_out", 32'(bus.out), 32'b11);
      chk("stall_sel", sel(), 1);
      chk("stall_cnt", 32'(bus.xfer_cnt), 5);
    end
    bus.out_ready = 1'b1;
    #1 chk("unstall_ack", 32'(bus.ack), 32'b0100);
    tick();
    chk("unstall_out", 32'(bus.out), 32'b01);
    chk("unstall_sel", sel(), 2);
    chk("unstall_cnt", 32'(bus.xfer_cnt), 6);

    // 5 skip/wrap from ptr=3
    bus.req = 4'b0101;
    tick();
    chk("wrap_sel0", sel(), 0);
    chk("wrap_out0", 32'(bus.out), 32'b11);
    tick();
    chk("wrap_sel1", sel(), 2);
    chk("wrap_out1", 32'(bus.out), 32'b01);
    chk("wrap_cnt",  32'(bus.xfer_cnt), 8);

    // 6 reset mid-stall (ptr=3 before reset)
    bus.out_ready = 1'b0;
    tick();
    chk("pre_rst_valid", 32'(bus.out_valid), 1);
    rst = 1'b1;
    #1 chk("rst_ack_gate", 32'(bus.ack), 0);
    tick();
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_cnt",   32'(bus.xfer_cnt), 0);
    rst = 1'b0; bus.req = 4'b1010; bus.out_ready = 1'b1;
    tick();
    chk("ptr0_sel", sel(), 1);
    rst = 1'b1; bus.req = 4'b0000;
    tick();
    rst = 1'b0; bus.req = 4'b1000;
    tick();
    chk("in4_sel", sel(), 3);
    chk("in4_out", 32'(bus.out), 32'b10);
    chk("in4_gnt", 32'(bus.gnt), 32'b1000);

    // reset wins over a completing transfer
    bus.req = 4'b0000; rst = 1'b1;
    tick();
    chk("rst_prio_cnt",   32'(bus.xfer_cnt), 0);
    chk("rst_prio_valid", 32'(bus.out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
